ysyx_22041207_pipe_ctrl: RTL and testbench

YSYX_22041207_PIPE_CTRL -- requirements
Module: ysyx_22041207_pipe_ctrl

---
 rtl/ysyx_22041207_pipe_ctrl.sv | 137 +++++++++++++
 tb/tb_ysyx_22041207_pipe_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041207_pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and data-memory waits,
// with a sticky memory-timeout flag and stall/flush performance counters.
module ysyx_22041207_pipe_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1addr,
  input  logic [4:0]  id_rs2addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rwaddr,
  input  logic        ex_writeRD,
  input  logic        ex_memoryReadWen,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        if_id_bubble,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        id_ex_flush,
  output logic        clear_afterID,
  output logic        ex_mem_bubble,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // The wait counter is only 8 bits wide, so larger limits clamp to its saturation value.
  localparam logic [7:0] TIMEOUT_LIM = (TIMEOUT > 255) ? 8'hFF : TIMEOUT[7:0];

  state_t     state;
  state_t     next_state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       mwait_cond;
  logic       lduse;
  logic       rs1_hit;
  logic       rs2_hit;

  assign mwait_cond = mem_req & ~mem_ready;
  assign rs1_hit    = id_uses_rs1 & (id_rs1addr == ex_rwaddr);
  assign rs2_hit    = id_uses_rs2 & (id_rs2addr == ex_rwaddr);
  assign lduse      = ex_memoryReadWen & ex_writeRD & (ex_rwaddr != 5'd0) & (rs1_hit | rs2_hit);
  assign wait_inc   = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
  assign state_o    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Priority is memory wait, then redirect, then load-use; controls are masked while in reset.
  always_comb begin
    next_state    = RUN;
    pc_stall      = 1'b0;
    if_id_bubble  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    id_ex_flush   = 1'b0;
    clear_afterID = 1'b0;
    ex_mem_bubble = 1'b0;
    if (mwait_cond) begin
      pc_stall      = 1'b1;
      if_id_bubble  = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      next_state    = MWAIT;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      next_state  = FLUSH;
    end else begin
      case (state)
        FLUSH: if_id_flush = 1'b1;
        RUN: begin
          if (lduse) begin
            pc_stall      = 1'b1;
            if_id_bubble  = 1'b1;
            clear_afterID = 1'b1;
          end
        end
        default: next_state = RUN;
      endcase
    end
    if (rst) begin
      pc_stall      = 1'b0;
      if_id_bubble  = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      id_ex_flush   = 1'b0;
      clear_afterID = 1'b0;
      ex_mem_bubble = 1'b0;
    end
  end

  // Each held memory-wait cycle counts; the first non-waiting cycle clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else if (mwait_cond) begin
      wait_cnt <= wait_inc;
      if (wait_inc >= TIMEOUT_LIM) begin
        mem_timeout <= 1'b1;
      end
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (pc_stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (id_ex_flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_pipe_ctrl.sv
// Directed testbench for ysyx_22041207_pipe_ctrl; stage controls are checked as a packed vector
// {pc_stall, if_id_bubble, if_id_flush, id_ex_bubble, id_ex_flush, clear_afterID, ex_mem_bubble}.
module tb_ysyx_22041207_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1addr;
  logic [4:0]  id_rs2addr;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rwaddr;
  logic        ex_writeRD;
  logic        ex_memoryReadWen;
  logic        ex_redirect;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_stall;
  logic        if_id_bubble;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        id_ex_flush;
  logic        clear_afterID;
  logic        ex_mem_bubble;
  logic        mem_timeout;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] CTL_NONE  = 7'b0000000;
  localparam logic [6:0] CTL_LDUSE = 7'b1100010;
  localparam logic [6:0] CTL_REDIR = 7'b0010100;
  localparam logic [6:0] CTL_FLUSH = 7'b0010000;
  localparam logic [6:0] CTL_HOLD  = 7'b1101001;

  logic [6:0] ctl;
  assign ctl = {pc_stall, if_id_bubble, if_id_flush, id_ex_bubble, id_ex_flush, clear_afterID, ex_mem_bubble};

  ysyx_22041207_pipe_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .id_rs1addr(id_rs1addr),
    .id_rs2addr(id_rs2addr),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .ex_rwaddr(ex_rwaddr),
    .ex_writeRD(ex_writeRD),
    .ex_memoryReadWen(ex_memoryReadWen),
    .ex_redirect(ex_redirect),
    .mem_req(mem_req),
    .mem_ready(mem_ready),
    .pc_stall(pc_stall),
    .if_id_bubble(if_id_bubble),
    .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .id_ex_flush(id_ex_flush),
    .clear_afterID(clear_afterID),
    .ex_mem_bubble(ex_mem_bubble),
    .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rw,
                               input logic wr, input logic ld, input logic redir,
                               input logic req, input logic rdy);
    id_rs1addr       = rs1;
    id_rs2addr       = rs2;
    id_uses_rs1      = u1;
    id_uses_rs2      = u2;
    ex_rwaddr        = rw;
    ex_writeRD       = wr;
    ex_memoryReadWen = ld;
    ex_redirect      = redir;
    mem_req          = req;
    mem_ready        = rdy;
  endtask

  // Inputs change on the falling edge; combinational controls are sampled 1 time unit later.
  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    #1;
    checkOutput("reset_ctl_masked", {25'd0, ctl}, {25'd0, CTL_NONE});
    checkOutput("reset_state", {30'd0, state_o}, 32'd0);
    checkOutput("reset_stall_cnt", stall_cnt, 32'd0);
    checkOutput("reset_flush_cnt", flush_cnt, 32'd0);
    checkOutput("reset_timeout", {31'd0, mem_timeout}, 32'd0);

    nextCycle();
    rst = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("idle_ctl", {25'd0, ctl}, {25'd0, CTL_NONE});

    // Load-use on rs1, then non-hazards: x0 destination and an unused rs2 match.
    nextCycle();
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("lduse_ctl", {25'd0, ctl}, {25'd0, CTL_LDUSE});
    nextCycle();
    checkOutput("lduse_state", {30'd0, state_o}, 32'd0);
    checkOutput("lduse_stall_cnt", stall_cnt, 32'd1);
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("lduse_x0_ctl", {25'd0, ctl}, {25'd0, CTL_NONE});
    nextCycle();
    applyStimulus(5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("rs2_unused_ctl", {25'd0, ctl}, {25'd0, CTL_NONE});
    nextCycle();
    applyStimulus(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("lduse_rs2_ctl", {25'd0, ctl}, {25'd0, CTL_LDUSE});
    nextCycle();
    checkOutput("lduse_rs2_stall_cnt", stall_cnt, 32'd2);

    // Plain redirect followed by the one-cycle fetch squash.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("redir_ctl", {25'd0, ctl}, {25'd0, CTL_REDIR});
    nextCycle();
    checkOutput("redir_state", {30'd0, state_o}, 32'd2);
    checkOutput("redir_flush_cnt", flush_cnt, 32'd1);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("flush_ctl", {25'd0, ctl}, {25'd0, CTL_FLUSH});
    nextCycle();
    checkOutput("flush_state", {30'd0, state_o}, 32'd0);
    checkOutput("flush_flush_cnt", flush_cnt, 32'd1);

    // Redirect together with load-use: flush wins and the load-use is ignored in FLUSH too.
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("redir_lduse_ctl", {25'd0, ctl}, {25'd0, CTL_REDIR});
    nextCycle();
    checkOutput("redir_lduse_state", {30'd0, state_o}, 32'd2);
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("flush_lduse_ctl", {25'd0, ctl}, {25'd0, CTL_FLUSH});
    nextCycle();
    checkOutput("flush_lduse_flush_cnt", flush_cnt, 32'd2);
    checkOutput("flush_lduse_stall_cnt", stall_cnt, 32'd2);

    // Three-cycle memory wait released on the ready cycle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1 checkOutput($sformatf("mwait_ctl_%0d", i), {25'd0, ctl}, {25'd0, CTL_HOLD});
      nextCycle();
      checkOutput($sformatf("mwait_state_%0d", i), {30'd0, state_o}, 32'd1);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 checkOutput("mready_ctl", {25'd0, ctl}, {25'd0, CTL_NONE});
    nextCycle();
    checkOutput("mready_state", {30'd0, state_o}, 32'd0);
    checkOutput("mwait_stall_cnt", stall_cnt, 32'd5);
    checkOutput("mwait_no_timeout", {31'd0, mem_timeout}, 32'd0);

    // Redirect during a memory wait is held off until the ready cycle.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1 checkOutput("mwait_redir_ctl", {25'd0, ctl}, {25'd0, CTL_HOLD});
    nextCycle();
    checkOutput("mwait_redir_state", {30'd0, state_o}, 32'd1);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1 checkOutput("mready_redir_ctl", {25'd0, ctl}, {25'd0, CTL_REDIR});
    nextCycle();
    checkOutput("mready_redir_state", {30'd0, state_o}, 32'd2);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("post_redir_flush_ctl", {25'd0, ctl}, {25'd0, CTL_FLUSH});
    nextCycle();
    checkOutput("post_redir_state", {30'd0, state_o}, 32'd0);
    checkOutput("post_redir_stall_cnt", stall_cnt, 32'd6);
    checkOutput("post_redir_flush_cnt", flush_cnt, 32'd3);

    // Six waiting cycles with TIMEOUT=4: the flag rises after the fourth and sticks.
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      nextCycle();
      checkOutput($sformatf("timeout_after_%0d", i), {31'd0, mem_timeout}, (i >= 4) ? 32'd1 : 32'd0);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    nextCycle();
    checkOutput("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
    checkOutput("timeout_stall_cnt", stall_cnt, 32'd12);

    // Asynchronous reset in the middle of a memory wait.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("pre_rst_state", {30'd0, state_o}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_state", {30'd0, state_o}, 32'd0);
    checkOutput("rst_mid_timeout", {31'd0, mem_timeout}, 32'd0);
    checkOutput("rst_mid_stall_cnt", stall_cnt, 32'd0);
    checkOutput("rst_mid_flush_cnt", flush_cnt, 32'd0);
    checkOutput("rst_mid_ctl", {25'd0, ctl}, {25'd0, CTL_NONE});
    nextCycle();
    rst = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall counter wrap from all-ones.
    nextCycle();
    applyStimulus(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    checkOutput("wrap_preload", stall_cnt, 32'hFFFF_FFFF);
    checkOutput("wrap_ctl", {25'd0, ctl}, {25'd0, CTL_LDUSE});
    nextCycle();
    checkOutput("wrap_stall_cnt", stall_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
